// File: rtl/dmi_arbiter.sv
// -----------------------------------------------------------------------------
// dmi_arbiter
//
// Round-robin arbiter sharing one debug-module DMI port between several debug
// transports (JTAG DTM, UART bridge, harness driver). One transaction is in
// flight at a time: a request is accepted from the winning requester, forwarded
// to the debug module, and the single response is routed back to the requester
// that issued it.
//
// Optional feature macro: DMI_ARB_TIMEOUT_EN
//   Defined   : a response watchdog aborts RESP after TimeoutCycles cycles,
//               returns status 2 (failed) to the requester and marks the late
//               target response as stale so it is absorbed later.
//   Undefined : RESP waits indefinitely; TimeoutCycles is unused.
//
// Parameters
//   NumReq          number of requesters (>= 1)
//   TimeoutCycles   response watchdog limit (>= 2), timeout build only
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   req_valid_i/ready_o per-requester request handshake (ready at most one-hot)
//   req_addr/op/data_i  per-requester request fields (7/2/32 bits)
//   resp_valid_o        one-hot response valid towards the granted requester
//   resp_ready_i        per-requester response ready
//   resp_data_o/op_o    response data and status, broadcast to all requesters
//   dmi_req_*           registered request towards the debug module
//   dmi_resp_*          response from the debug module
//   busy_o              high whenever a transaction is in progress
//   grant_id_o          index of the current or most recent grant
// -----------------------------------------------------------------------------
module dmi_arbiter #(
    parameter int unsigned NumReq        = 2,
    parameter int unsigned TimeoutCycles = 1024,
    localparam int unsigned GrantW       = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,

    input  logic [NumReq-1:0]      req_valid_i,
    output logic [NumReq-1:0]      req_ready_o,
    input  logic [NumReq-1:0][6:0] req_addr_i,
    input  logic [NumReq-1:0][1:0] req_op_i,
    input  logic [NumReq-1:0][31:0] req_data_i,

    output logic [NumReq-1:0]      resp_valid_o,
    input  logic [NumReq-1:0]      resp_ready_i,
    output logic [31:0]            resp_data_o,
    output logic [1:0]             resp_op_o,

    output logic                   dmi_req_valid_o,
    input  logic                   dmi_req_ready_i,
    output logic [6:0]             dmi_req_addr_o,
    output logic [1:0]             dmi_req_op_o,
    output logic [31:0]            dmi_req_data_o,

    input  logic                   dmi_resp_valid_i,
    output logic                   dmi_resp_ready_o,
    input  logic [31:0]            dmi_resp_data_i,
    input  logic [1:0]             dmi_resp_op_i,

    output logic                   busy_o,
    output logic [GrantW-1:0]      grant_id_o
);

    // Elaboration-time parameter sanity checks.
    if (NumReq < 32'd1) begin : g_bad_numreq
        $error("dmi_arbiter: NumReq must be at least 1");
    end
    if (TimeoutCycles < 32'd2) begin : g_bad_timeout
        $error("dmi_arbiter: TimeoutCycles must be at least 2");
    end

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StReq     = 2'd1,
        StResp    = 2'd2,
        StDeliver = 2'd3
    } state_e;

    localparam logic [1:0] OpFailed = 2'd2;

    state_e              state_q, state_d;
    logic [GrantW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [GrantW-1:0]   grant_id_q, grant_id_d;
    logic [6:0]          addr_q, addr_d;
    logic [1:0]          op_q, op_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [1:0]          rop_q, rop_d;

    logic                win_found_s;
    logic [GrantW-1:0]   win_idx_s;
    logic [NumReq-1:0]   req_ready_s;
    logic [NumReq-1:0]   resp_valid_s;
    logic                dmi_resp_ready_s;
    logic                stale_s;

`ifdef DMI_ARB_TIMEOUT_EN
    logic                stale_q, stale_d;
    logic [31:0]         tmo_cnt_q, tmo_cnt_d;
    logic                tmo_hit_s;

    assign stale_s   = stale_q;
    assign tmo_hit_s = (tmo_cnt_q == (TimeoutCycles - 32'd1));
`else
    assign stale_s   = 1'b0;
`endif

    // Pointer advance after a completed transaction, wrapping after NumReq-1.
    function automatic logic [GrantW-1:0] next_ptr(input logic [GrantW-1:0] id);
        logic [GrantW-1:0] nxt;
        if (32'(id) >= (NumReq - 32'd1)) begin
            nxt = '0;
        end else begin
            nxt = id + GrantW'(1);
        end
        return nxt;
    endfunction

    // Round-robin winner: lowest valid index at or after rr_ptr, else lowest
    // valid index overall (which is then necessarily below rr_ptr, i.e. wrapped).
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        for (int unsigned j = 0; j < NumReq; j++) begin
            if (!win_found_s && req_valid_i[j] && (j >= 32'(rr_ptr_q))) begin
                win_found_s = 1'b1;
                win_idx_s   = GrantW'(j);
            end else begin
                win_found_s = win_found_s;
            end
        end
        for (int unsigned j = 0; j < NumReq; j++) begin
            if (!win_found_s && req_valid_i[j]) begin
                win_found_s = 1'b1;
                win_idx_s   = GrantW'(j);
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // FSM next-state, capture-register updates and handshake strobes.
    always_comb begin
        state_d          = state_q;
        rr_ptr_d         = rr_ptr_q;
        grant_id_d       = grant_id_q;
        addr_d           = addr_q;
        op_d             = op_q;
        wdata_d          = wdata_q;
        rdata_d          = rdata_q;
        rop_d            = rop_q;
        req_ready_s      = '0;
        dmi_resp_ready_s = 1'b0;
`ifdef DMI_ARB_TIMEOUT_EN
        stale_d          = stale_q;
        tmo_cnt_d        = tmo_cnt_q;
`endif

        case (state_q)
            StIdle: begin
                if (stale_s) begin
                    // A timed-out response may still arrive: swallow it before
                    // any new grant so it cannot be matched to a new request.
                    dmi_resp_ready_s = 1'b1;
`ifdef DMI_ARB_TIMEOUT_EN
                    if (dmi_resp_valid_i) begin
                        stale_d = 1'b0;
                    end else begin
                        stale_d = stale_q;
                    end
`endif
                end else if (win_found_s) begin
                    // The winner has valid high, so raising its ready completes
                    // the handshake in this cycle.
                    req_ready_s[win_idx_s] = 1'b1;
                    grant_id_d             = win_idx_s;
                    addr_d                 = req_addr_i[win_idx_s];
                    op_d                   = req_op_i[win_idx_s];
                    wdata_d                = req_data_i[win_idx_s];
                    state_d                = StReq;
                end else begin
                    state_d = StIdle;
                end
            end

            StReq: begin
                if (dmi_req_ready_i) begin
                    state_d = StResp;
`ifdef DMI_ARB_TIMEOUT_EN
                    tmo_cnt_d = 32'd0;
`endif
                end else begin
                    state_d = StReq;
                end
            end

            StResp: begin
                dmi_resp_ready_s = 1'b1;
                // A response in the timeout cycle takes priority over the abort.
                if (dmi_resp_valid_i) begin
                    rdata_d = dmi_resp_data_i;
                    rop_d   = dmi_resp_op_i;
                    state_d = StDeliver;
`ifdef DMI_ARB_TIMEOUT_EN
                end else if (tmo_hit_s) begin
                    rdata_d = 32'h0000_0000;
                    rop_d   = OpFailed;
                    stale_d = 1'b1;
                    state_d = StDeliver;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 32'd1;
                    state_d   = StResp;
                end
`else
                end else begin
                    state_d = StResp;
                end
`endif
            end

            StDeliver: begin
                // Only the granted requester's ready completes the delivery.
                if (resp_ready_i[grant_id_q]) begin
                    rr_ptr_d = next_ptr(grant_id_q);
                    state_d  = StIdle;
                end else begin
                    state_d = StDeliver;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // One-hot response valid towards the granted requester while delivering.
    always_comb begin
        resp_valid_s = '0;
        if (state_q == StDeliver) begin
            resp_valid_s[grant_id_q] = 1'b1;
        end else begin
            resp_valid_s = '0;
        end
    end

    // State and capture registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            addr_q     <= 7'h00;
            op_q       <= 2'd0;
            wdata_q    <= 32'h0000_0000;
            rdata_q    <= 32'h0000_0000;
            rop_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            addr_q     <= addr_d;
            op_q       <= op_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            rop_q      <= rop_d;
        end
    end

`ifdef DMI_ARB_TIMEOUT_EN
    // Watchdog counter and stale-response flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stale_q   <= 1'b0;
            tmo_cnt_q <= 32'd0;
        end else begin
            stale_q   <= stale_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`endif

    assign req_ready_o      = req_ready_s;
    assign resp_valid_o     = resp_valid_s;
    assign resp_data_o      = rdata_q;
    assign resp_op_o        = rop_q;
    assign dmi_req_valid_o  = (state_q == StReq);
    assign dmi_req_addr_o   = addr_q;
    assign dmi_req_op_o     = op_q;
    assign dmi_req_data_o   = wdata_q;
    assign dmi_resp_ready_o = dmi_resp_ready_s;
    assign busy_o           = (state_q != StIdle);
    assign grant_id_o       = grant_id_q;

endmodule

// File: tb/tb_dmi_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmi_arbiter
//
// Directed bench for dmi_arbiter (NumReq = 2, TimeoutCycles = 8). Expected
// requests and responses are queued when stimulus is driven; a negedge monitor
// pops and compares them when the DUT hands them over. A small target model
// answers each forwarded request with data = tgt_base ^ write data.
// -----------------------------------------------------------------------------
module tb_dmi_arbiter;

    localparam int unsigned NReq = 2;

    logic                  clk;
    logic                  rst_i;
    logic [NReq-1:0]       req_valid_i;
    logic [NReq-1:0]       req_ready_o;
    logic [NReq-1:0][6:0]  req_addr_i;
    logic [NReq-1:0][1:0]  req_op_i;
    logic [NReq-1:0][31:0] req_data_i;
    logic [NReq-1:0]       resp_valid_o;
    logic [NReq-1:0]       resp_ready_i;
    logic [31:0]           resp_data_o;
    logic [1:0]            resp_op_o;
    logic                  dmi_req_valid_o;
    logic                  dmi_req_ready_i;
    logic [6:0]            dmi_req_addr_o;
    logic [1:0]            dmi_req_op_o;
    logic [31:0]           dmi_req_data_o;
    logic                  dmi_resp_valid_i;
    logic                  dmi_resp_ready_o;
    logic [31:0]           dmi_resp_data_i;
    logic [1:0]            dmi_resp_op_i;
    logic                  busy_o;
    logic [0:0]            grant_id_o;

    int checks = 0;
    int errors = 0;
    int grants = 0;

    typedef struct {
        logic [6:0]  addr;
        logic [1:0]  op;
        logic [31:0] data;
    } req_t;

    typedef struct {
        logic [0:0]  id;
        logic [31:0] data;
        logic [1:0]  op;
    } resp_t;

    req_t  req_q[$];
    resp_t resp_q[$];

    // Target model controls and state
    logic        tgt_resp_en;
    logic [31:0] tgt_base;
    logic [1:0]  tgt_rop;
    logic        tgt_pend_q;
    logic [31:0] tgt_rdata_q;

    dmi_arbiter #(
        .NumReq        (NReq),
        .TimeoutCycles (8)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_addr_i       (req_addr_i),
        .req_op_i         (req_op_i),
        .req_data_i       (req_data_i),
        .resp_valid_o     (resp_valid_o),
        .resp_ready_i     (resp_ready_i),
        .resp_data_o      (resp_data_o),
        .resp_op_o        (resp_op_o),
        .dmi_req_valid_o  (dmi_req_valid_o),
        .dmi_req_ready_i  (dmi_req_ready_i),
        .dmi_req_addr_o   (dmi_req_addr_o),
        .dmi_req_op_o     (dmi_req_op_o),
        .dmi_req_data_o   (dmi_req_data_o),
        .dmi_resp_valid_i (dmi_resp_valid_i),
        .dmi_resp_ready_o (dmi_resp_ready_o),
        .dmi_resp_data_i  (dmi_resp_data_i),
        .dmi_resp_op_i    (dmi_resp_op_i),
        .busy_o           (busy_o),
        .grant_id_o       (grant_id_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Target: one outstanding request, answers when enabled, reset with the DUT.
    always @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            tgt_pend_q  <= 1'b0;
            tgt_rdata_q <= 32'h0;
        end else if (dmi_req_valid_o && dmi_req_ready_i) begin
            tgt_pend_q  <= 1'b1;
            tgt_rdata_q <= tgt_base ^ dmi_req_data_o;
        end else if (dmi_resp_valid_i && dmi_resp_ready_o) begin
            tgt_pend_q  <= 1'b0;
        end
    end

    assign dmi_resp_valid_i = tgt_pend_q & tgt_resp_en;
    assign dmi_resp_data_i  = tgt_rdata_q;
    assign dmi_resp_op_i    = tgt_rop;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: handshakes that will complete at the next posedge.
    always @(negedge clk) begin
        if (rst_i === 1'b0) begin
            if ((resp_valid_o & resp_ready_i) != 2'b00) begin
                if (resp_q.size() == 0) begin
                    chk("resp_unexpected", 64'(resp_valid_o), 64'd0);
                end else begin
                    resp_t e;
                    logic [1:0] ev;
                    e  = resp_q.pop_front();
                    ev = 2'b01 << e.id;
                    chk("resp_valid_onehot", 64'(resp_valid_o), 64'(ev));
                    chk("resp_grant_id", 64'(grant_id_o), 64'(e.id));
                    chk("resp_data", 64'(resp_data_o), 64'(e.data));
                    chk("resp_op", 64'(resp_op_o), 64'(e.op));
                end
            end
            if (dmi_req_valid_o && dmi_req_ready_i) begin
                if (req_q.size() == 0) begin
                    chk("dmi_req_unexpected", 64'(dmi_req_valid_o), 64'd0);
                end else begin
                    req_t r;
                    r = req_q.pop_front();
                    chk("dmi_req_addr", 64'(dmi_req_addr_o), 64'(r.addr));
                    chk("dmi_req_op", 64'(dmi_req_op_o), 64'(r.op));
                    chk("dmi_req_data", 64'(dmi_req_data_o), 64'(r.data));
                end
            end
            if ((req_valid_i & req_ready_o) != 2'b00) begin
                grants++;
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        #3;
    endtask

    task automatic drive_req(input int idx, input logic [6:0] a, input logic [1:0] o, input logic [31:0] d);
        req_addr_i[idx] = a;
        req_op_i[idx]   = o;
        req_data_i[idx] = d;
    endtask

    task automatic expect_txn(input logic [0:0] id, input logic [6:0] a, input logic [1:0] o,
                              input logic [31:0] d, input logic [1:0] rop);
        req_t  r;
        resp_t e;
        r.addr = a;  r.op = o;  r.data = d;
        e.id = id;   e.data = tgt_base ^ d;  e.op = rop;
        req_q.push_back(r);
        resp_q.push_back(e);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy_o !== 1'b0 || resp_q.size() != 0) && n < 60) begin
            nxt();
            smp();
            n++;
        end
        chk({tag, "_idle"}, 64'(busy_o), 64'd0);
        chk({tag, "_drained"}, 64'(resp_q.size()), 64'd0);
    endtask

    initial begin
        int n;
        int g0;
        rst_i           = 1'b1;
        req_valid_i     = 2'b00;
        resp_ready_i    = 2'b00;
        req_addr_i      = '0;
        req_op_i        = '0;
        req_data_i      = '0;
        dmi_req_ready_i = 1'b1;
        tgt_resp_en     = 1'b1;
        tgt_base        = 32'h0;
        tgt_rop         = 2'd0;

        // ---------------- reset state ----------------
        nxt(); nxt(); smp();
        chk("rst_req_ready", 64'(req_ready_o), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid_o), 64'd0);
        chk("rst_dmi_req_valid", 64'(dmi_req_valid_o), 64'd0);
        chk("rst_dmi_resp_ready", 64'(dmi_resp_ready_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_grant_id", 64'(grant_id_o), 64'd0);
        chk("rst_resp_data_op", {30'd0, resp_op_o, resp_data_o}, 64'd0);
        chk("rst_dmi_req_fields", {23'd0, dmi_req_addr_o, dmi_req_op_o, dmi_req_data_o}, 64'd0);
        nxt();
        rst_i = 1'b0;

        // ---------------- single read, latency ----------------
        nxt();
        tgt_base     = 32'h0000_0C02;
        resp_ready_i = 2'b01;
        drive_req(0, 7'h11, 2'd1, 32'h0);
        req_valid_i  = 2'b01;
        expect_txn(1'b0, 7'h11, 2'd1, 32'h0, 2'd0);
        smp();
        chk("rd_c0_req_ready", 64'(req_ready_o), 64'd1);
        chk("rd_c0_busy", 64'(busy_o), 64'd0);
        nxt(); req_valid_i = 2'b00; smp();
        chk("rd_c1_dmi_req_valid", 64'(dmi_req_valid_o), 64'd1);
        nxt(); smp();
        chk("rd_c2_dmi_resp_ready", 64'(dmi_resp_ready_o), 64'd1);
        chk("rd_c2_resp_valid", 64'(resp_valid_o), 64'd0);
        nxt(); smp();
        chk("rd_c3_resp_valid", 64'(resp_valid_o), 64'd1);
        chk("rd_c3_resp_data", 64'(resp_data_o), 64'h0000_0C02);
        nxt(); smp();
        chk("rd_c4_busy", 64'(busy_o), 64'd0);

        // ---------------- reset while waiting in RESP ----------------
        tgt_resp_en = 1'b0;
        nxt();
        drive_req(1, 7'h55, 2'd1, 32'h0);
        req_valid_i = 2'b10;
        req_q.push_back('{addr: 7'h55, op: 2'd1, data: 32'h0});
        smp();
        chk("rst_mid_grant1", 64'(req_ready_o), 64'd2);
        nxt(); req_valid_i = 2'b00;
        nxt(); smp();
        chk("rst_mid_in_resp", 64'(dmi_resp_ready_o), 64'd1);
        chk("rst_mid_gid", 64'(grant_id_o), 64'd1);
        nxt();
        #2 rst_i = 1'b1;
        #1;
        chk("rst_async_busy", 64'(busy_o), 64'd0);
        chk("rst_async_dmi_resp_ready", 64'(dmi_resp_ready_o), 64'd0);
        chk("rst_async_gid", 64'(grant_id_o), 64'd0);
        chk("rst_async_dmi_addr", 64'(dmi_req_addr_o), 64'd0);
        nxt();
        rst_i       = 1'b0;
        tgt_resp_en = 1'b1;

        // ---------------- contention: grants 0,1,0,1 ----------------
        nxt();
        tgt_base     = 32'hA5A5_0000;
        resp_ready_i = 2'b11;
        drive_req(0, 7'h20, 2'd2, 32'h1111_0001);
        drive_req(1, 7'h21, 2'd1, 32'h2222_0002);
        for (int k = 0; k < 2; k++) begin
            expect_txn(1'b0, 7'h20, 2'd2, 32'h1111_0001, 2'd0);
            expect_txn(1'b1, 7'h21, 2'd1, 32'h2222_0002, 2'd0);
        end
        g0 = grants;
        req_valid_i = 2'b11;
        smp();
        chk("cont_first_grant0", 64'(req_ready_o), 64'd1);
        n = 0;
        while (grants < g0 + 4 && n < 60) begin
            nxt(); smp(); n++;
        end
        chk("cont_four_grants", 64'(grants - g0), 64'd4);
        nxt(); req_valid_i = 2'b00;
        wait_idle("cont");

        // ---------------- backpressure + ignored stray ready ----------------
        nxt();
        dmi_req_ready_i = 1'b0;
        resp_ready_i    = 2'b00;
        tgt_base        = 32'h0F0F_F0F0;
        tgt_rop         = 2'd3;
        drive_req(1, 7'h5A, 2'd2, 32'hDEAD_BEEF);
        req_valid_i = 2'b10;
        expect_txn(1'b1, 7'h5A, 2'd2, 32'hDEAD_BEEF, 2'd3);
        smp();
        chk("bp_grant1", 64'(req_ready_o), 64'd2);
        nxt(); req_valid_i = 2'b00;
        for (int k = 0; k < 5; k++) begin
            nxt(); smp();
            chk("bp_req_valid_held", 64'(dmi_req_valid_o), 64'd1);
            chk("bp_req_fields_stable", {23'd0, dmi_req_addr_o, dmi_req_op_o, dmi_req_data_o},
                {23'd0, 7'h5A, 2'd2, 32'hDEAD_BEEF});
        end
        nxt(); dmi_req_ready_i = 1'b1;
        n = 0;
        while (resp_valid_o == 2'b00 && n < 10) begin
            nxt(); smp(); n++;
        end
        chk("bp_deliver_req1", 64'(resp_valid_o), 64'd2);
        nxt();
        tgt_rop = 2'd0;
        drive_req(0, 7'h0F, 2'd1, 32'h0000_0033);
        req_valid_i  = 2'b01;
        resp_ready_i = 2'b01;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) nxt();
            smp();
            chk("bp_resp_valid_held", 64'(resp_valid_o), 64'd2);
            chk("bp_no_new_grant", 64'(req_ready_o), 64'd0);
            chk("bp_resp_data_stable", 64'(resp_data_o), 64'(32'hDEAD_BEEF ^ 32'h0F0F_F0F0));
        end
        nxt();
        resp_ready_i = 2'b11;
        expect_txn(1'b0, 7'h0F, 2'd1, 32'h0000_0033, 2'd0);
        n = 0;
        while (req_ready_o[0] !== 1'b1 && n < 10) begin
            nxt(); smp(); n++;
        end
        chk("bp_req0_granted_after", 64'(req_ready_o), 64'd1);
        nxt(); req_valid_i = 2'b00;
        wait_idle("bp");

`ifdef DMI_ARB_TIMEOUT_EN
        // ---------------- response timeout and stale absorption ----------------
        nxt();
        tgt_resp_en  = 1'b0;
        resp_ready_i = 2'b01;
        drive_req(0, 7'h33, 2'd1, 32'h0);
        req_valid_i = 2'b01;
        req_q.push_back('{addr: 7'h33, op: 2'd1, data: 32'h0});
        resp_q.push_back('{id: 1'b0, data: 32'h0, op: 2'd2});
        smp();
        chk("to_grant0", 64'(req_ready_o), 64'd1);
        nxt(); req_valid_i = 2'b00;
        for (int k = 0; k < 8; k++) begin
            nxt(); smp();
            chk("to_waiting", 64'(resp_valid_o), 64'd0);
        end
        nxt(); smp();
        chk("to_deliver", 64'(resp_valid_o), 64'd1);
        chk("to_op_failed", 64'(resp_op_o), 64'd2);
        chk("to_data_zero", 64'(resp_data_o), 64'd0);
        nxt();
        tgt_base = 32'h5555_0000;
        drive_req(1, 7'h44, 2'd2, 32'h1234_5678);
        req_valid_i = 2'b10;
        for (int k = 0; k < 2; k++) begin
            if (k > 0) nxt();
            smp();
            chk("to_stale_no_grant", 64'(req_ready_o), 64'd0);
            chk("to_stale_resp_ready", 64'(dmi_resp_ready_o), 64'd1);
        end
        nxt();
        tgt_resp_en = 1'b1;
        expect_txn(1'b1, 7'h44, 2'd2, 32'h1234_5678, 2'd0);
        smp();
        chk("to_absorb_no_resp", 64'(resp_valid_o), 64'd0);
        chk("to_absorb_no_grant", 64'(req_ready_o), 64'd0);
        nxt();
        resp_ready_i = 2'b11;
        smp();
        chk("to_grant_after_absorb", 64'(req_ready_o), 64'd2);
        nxt(); req_valid_i = 2'b00;
        wait_idle("to");
`endif

        chk("req_queue_drained", 64'(req_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
